// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between instruction fetch (I) and data (D) requesters.
// D has priority, bounded by a streak limit while fetch waits; WAIT is guarded by an ack timeout.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid
);

    localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam int TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic OWNER_D = 1'b0;
    localparam logic OWNER_I = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic                owner_r, owner_s;
    logic                wr_r, wr_s;
    logic [STREAK_W-1:0] streak_r, streak_s;
    logic [TMO_W-1:0]    tmo_r, tmo_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic                i_done_r, i_done_s;
    logic [DATA_W-1:0]   i_rdata_r, i_rdata_s;
    logic                d_done_r, d_done_s;
    logic [DATA_W-1:0]   d_rdata_r, d_rdata_s;
    logic                err_r, err_s;
    logic                busy_r, busy_s;
    logic                mem_enable_r, mem_enable_s;
    logic                mem_wr_r, mem_wr_s;
    logic [DATA_W-1:0]   capture_s;

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] value);
        logic [STREAK_W-1:0] result;
        if (value == STREAK_MAX) begin
            result = value;
        end else begin
            result = value + STREAK_W'(1);
        end
        return result;
    endfunction

    // Next-state and next-output computation; every output is registered from these values.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        wr_s         = wr_r;
        streak_s     = streak_r;
        tmo_s        = tmo_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        i_done_s     = 1'b0;
        i_rdata_s    = {DATA_W{1'b0}};
        d_done_s     = 1'b0;
        d_rdata_s    = {DATA_W{1'b0}};
        err_s        = 1'b0;
        mem_enable_s = 1'b0;
        mem_wr_s     = 1'b0;
        capture_s    = {DATA_W{1'b0}};

        case (state_r)
            ST_IDLE: begin
                // Data wins unless fetch is waiting and data already used its whole streak.
                if (d_req && !(i_req && (streak_r == STREAK_MAX))) begin
                    state_s      = ST_ISSUE;
                    owner_s      = OWNER_D;
                    wr_s         = d_wr;
                    addr_s       = d_addr;
                    wdata_s      = d_wdata;
                    streak_s     = sat_inc(streak_r);
                    mem_enable_s = 1'b1;
                    mem_wr_s     = d_wr;
                end else if (i_req) begin
                    state_s      = ST_ISSUE;
                    owner_s      = OWNER_I;
                    wr_s         = 1'b0;
                    addr_s       = i_addr;
                    wdata_s      = {DATA_W{1'b0}};
                    streak_s     = {STREAK_W{1'b0}};
                    mem_enable_s = 1'b1;
                    mem_wr_s     = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
                tmo_s   = {TMO_W{1'b0}};
            end
            ST_WAIT: begin
                if (mem_data_valid) begin
                    state_s = ST_DONE;
                    // Write acks carry no data back to the requester.
                    if (wr_r) begin
                        capture_s = {DATA_W{1'b0}};
                    end else begin
                        capture_s = mem_rdata;
                    end
                    err_s = 1'b0;
                end else if (tmo_r == TMO_LAST) begin
                    state_s   = ST_DONE;
                    capture_s = {DATA_W{1'b0}};
                    err_s     = 1'b1;
                    tmo_s     = tmo_r + TMO_W'(1);
                end else begin
                    state_s = ST_WAIT;
                    tmo_s   = tmo_r + TMO_W'(1);
                end
                if (state_s == ST_DONE) begin
                    if (owner_r == OWNER_I) begin
                        i_done_s  = 1'b1;
                        i_rdata_s = capture_s;
                    end else begin
                        d_done_s  = 1'b1;
                        d_rdata_s = capture_s;
                    end
                end else begin
                    i_done_s = 1'b0;
                    d_done_s = 1'b0;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, bookkeeping and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWNER_D;
            wr_r         <= 1'b0;
            streak_r     <= {STREAK_W{1'b0}};
            tmo_r        <= {TMO_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            i_done_r     <= 1'b0;
            i_rdata_r    <= {DATA_W{1'b0}};
            d_done_r     <= 1'b0;
            d_rdata_r    <= {DATA_W{1'b0}};
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            mem_enable_r <= 1'b0;
            mem_wr_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            wr_r         <= wr_s;
            streak_r     <= streak_s;
            tmo_r        <= tmo_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            i_done_r     <= i_done_s;
            i_rdata_r    <= i_rdata_s;
            d_done_r     <= d_done_s;
            d_rdata_r    <= d_rdata_s;
            err_r        <= err_s;
            busy_r       <= busy_s;
            mem_enable_r <= mem_enable_s;
            mem_wr_r     <= mem_wr_s;
        end
    end

    assign i_done     = i_done_r;
    assign i_rdata    = i_rdata_r;
    assign d_done     = d_done_r;
    assign d_rdata    = d_rdata_r;
    assign err        = err_r;
    assign busy       = busy_r;
    assign mem_enable = mem_enable_r;
    assign mem_wr     = mem_wr_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model predicts every cycle's outputs from
// grant time plus memory latency; directed scenarios pin the model with literal values.
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXS = 4;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          rst, i_req, d_req, d_wr, mem_data_valid;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_done, d_done, err, busy, mem_enable, mem_wr;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err), .busy(busy),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Transaction model: one access in flight, described by its issue and done cycles.
    logic [15:0] mem_m [logic [15:0]];
    bit          busy_m, freed, rst_pend, owner_m, wr_m, err_m;
    int          issue_c, done_c, lat_m, streak_m;
    logic [15:0] addr_m, wdata_m, rdata_m;

    bit          exp_i_done, exp_d_done, exp_err, exp_busy, exp_en, exp_mwr;
    logic [15:0] exp_i_rdata, exp_d_rdata, exp_addr, exp_wdata;

    bit rand_mode, renew_d, renew_i;
    int lat_force, extra_valid_cyc;

    int          en_cnt, i_cnt, d_cnt, busy_cnt, last_en_cyc, last_i_cyc, last_d_cyc, order_n;
    logic        en_wr, last_err;
    logic [15:0] en_addr, en_wdata, last_i_rdata, last_d_rdata;
    logic [31:0] order_bits;

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick_latency();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return TMO + 10;
        if (r == 1) return TMO;
        return $urandom_range(1, 5);
    endfunction

    task automatic new_i_random();
        i_req  = 1'b1;
        i_addr = 16'($urandom_range(0, 63));
    endtask

    task automatic new_d_random();
        d_req   = 1'b1;
        d_wr    = 1'($urandom_range(0, 1));
        d_addr  = 16'($urandom_range(0, 63));
        d_wdata = 16'($urandom);
    endtask

    // Arbitration decision for the edge that ends the current cycle.
    task automatic decide();
        int lat;
        if (rst) begin
            rst_pend = 1'b1;
            return;
        end
        if (busy_m || freed) return;
        if (d_req && !(i_req && streak_m == MAXS)) begin
            owner_m = 1'b0; wr_m = d_wr; addr_m = d_addr; wdata_m = d_wdata;
            if (streak_m < MAXS) streak_m++;
        end else if (i_req) begin
            owner_m = 1'b1; wr_m = 1'b0; addr_m = i_addr; wdata_m = 16'h0000;
            streak_m = 0;
        end else begin
            return;
        end
        lat     = (lat_force != 0) ? lat_force : pick_latency();
        busy_m  = 1'b1;
        issue_c = cyc + 1;
        lat_m   = lat;
        if (lat > TMO) begin
            err_m = 1'b1; rdata_m = 16'h0000; done_c = issue_c + TMO + 1;
        end else begin
            err_m = 1'b0; rdata_m = wr_m ? 16'h0000 : mem_read(addr_m); done_c = issue_c + lat + 1;
        end
    endtask

    task automatic compare_outputs();
        chk("i_done", i_done, exp_i_done);
        chk("d_done", d_done, exp_d_done);
        chk("i_rdata", i_rdata, exp_i_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        chk("err", err, exp_err);
        chk("busy", busy, exp_busy);
        chk("mem_enable", mem_enable, exp_en);
        if (exp_en) chk("mem_wr", mem_wr, exp_mwr);
        if (exp_busy) chk("mem_addr", mem_addr, exp_addr);
        if (exp_mwr) chk("mem_wdata", mem_wdata, exp_wdata);
        if (mem_enable === 1'b1) begin
            en_cnt++; last_en_cyc = cyc; en_addr = mem_addr; en_wr = mem_wr; en_wdata = mem_wdata;
        end
        if (i_done === 1'b1) begin
            i_cnt++; last_i_cyc = cyc; last_i_rdata = i_rdata;
        end
        if (d_done === 1'b1) begin
            d_cnt++; last_d_cyc = cyc; last_d_rdata = d_rdata; last_err = err;
        end
        if (i_done === 1'b1 || d_done === 1'b1) begin
            if (order_n < 32) order_bits[order_n] = i_done;
            order_n++;
        end
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic step();
        decide();
        @(posedge clk);
        #1;
        cyc++;
        freed = 1'b0;
        if (rst_pend) begin
            busy_m = 1'b0; streak_m = 0; rst_pend = 1'b0;
        end
        exp_i_done = 1'b0; exp_d_done = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
        exp_en = 1'b0; exp_mwr = 1'b0; exp_i_rdata = 16'h0000; exp_d_rdata = 16'h0000;
        exp_addr = addr_m; exp_wdata = wdata_m;
        if (busy_m) begin
            exp_busy = 1'b1;
            exp_en   = (cyc == issue_c);
            exp_mwr  = exp_en && wr_m;
            if (cyc == done_c) begin
                exp_err = err_m;
                if (owner_m) begin
                    exp_i_done = 1'b1; exp_i_rdata = rdata_m;
                    if (rand_mode && $urandom_range(0, 1) == 1) new_i_random();
                    else if (rand_mode || !renew_i) i_req = 1'b0;
                end else begin
                    exp_d_done = 1'b1; exp_d_rdata = rdata_m;
                    if (rand_mode && $urandom_range(0, 1) == 1) new_d_random();
                    else if (rand_mode || !renew_d) d_req = 1'b0;
                end
                busy_m = 1'b0;
                freed  = 1'b1;
            end
        end
        mem_data_valid = 1'b0;
        mem_rdata      = 16'($urandom);
        if (busy_m && !err_m && cyc == issue_c + lat_m) begin
            mem_data_valid = 1'b1;
            mem_rdata      = mem_read(addr_m);
            if (wr_m) mem_m[addr_m] = wdata_m;
        end
        if (cyc == extra_valid_cyc) begin
            mem_data_valid = 1'b1;
            mem_rdata      = 16'hDEAD;
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic clear_log();
        en_cnt = 0; i_cnt = 0; d_cnt = 0; busy_cnt = 0; order_n = 0; order_bits = 32'h0;
        last_en_cyc = -1; last_i_cyc = -1; last_d_cyc = -1;
    endtask

    task automatic wait_done(input bit want_i, input int bound);
        int start;
        bit got;
        start = want_i ? i_cnt : d_cnt;
        got   = 1'b0;
        for (int k = 0; k < bound && !got; k++) begin
            step();
            got = ((want_i ? i_cnt : d_cnt) != start);
        end
        if (want_i) chk("wait_i_done", 32'(got), 32'd1);
        else        chk("wait_d_done", 32'(got), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; i_addr = 16'h0; d_addr = 16'h0;
        d_wdata = 16'h0; mem_rdata = 16'h0; mem_data_valid = 1'b0;
        busy_m = 1'b0; freed = 1'b0; rst_pend = 1'b0; owner_m = 1'b0; wr_m = 1'b0; err_m = 1'b0;
        issue_c = 0; done_c = 0; lat_m = 0; streak_m = 0;
        addr_m = 16'h0; wdata_m = 16'h0; rdata_m = 16'h0;
        rand_mode = 1'b0; renew_d = 1'b0; renew_i = 1'b0; lat_force = 1; extra_valid_cyc = -1;
        clear_log();

        repeat (3) step();
        chk("reset_busy", busy, 1'b0);
        chk("reset_mem_addr", mem_addr, 16'h0000);
        chk("reset_pulses", {i_done, d_done, err, mem_enable}, 4'h0);
        rst = 1'b0;
        step(); step();

        // Single read; the sample cycle counts as cycle 1, so d_done lands 3 cycles later.
        mem_m[16'h0010] = 16'hBEEF; lat_force = 1; clear_log();
        c0 = cyc; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010; d_wdata = 16'h5555;
        wait_done(1'b0, 20);
        chk("rd_done_cycle", last_d_cyc - c0, 3);
        chk("rd_rdata", last_d_rdata, 16'hBEEF);
        chk("rd_en_count", en_cnt, 1);
        chk("rd_en_cycle", last_en_cyc - c0, 1);
        chk("rd_en_addr", en_addr, 16'h0010);
        chk("rd_no_i_done", i_cnt, 0);
        step(); step();

        // Write completes with zero read data.
        clear_log();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        wait_done(1'b0, 20);
        chk("wr_en_count", en_cnt, 1);
        chk("wr_mem_wr", en_wr, 1'b1);
        chk("wr_mem_wdata", en_wdata, 16'h1234);
        chk("wr_rdata", last_d_rdata, 16'h0000);
        chk("wr_err", last_err, 1'b0);
        step(); step();

        // Memory never acknowledges.
        lat_force = 100; clear_log();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0030;
        wait_done(1'b0, 40);
        chk("tmo_done_after_issue", last_d_cyc - last_en_cyc, TMO + 1);
        chk("tmo_err", last_err, 1'b1);
        chk("tmo_rdata", last_d_rdata, 16'h0000);
        step();
        chk("tmo_busy_after", busy, 1'b0);
        step();

        // Reset during WAIT, then a stale ack one cycle after release.
        clear_log();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        repeat (3) step();
        rst = 1'b1; d_req = 1'b0;
        step();
        rst = 1'b0; extra_valid_cyc = cyc + 1;
        repeat (4) step();
        chk("rstmid_no_d_done", d_cnt, 0);
        chk("rstmid_no_i_done", i_cnt, 0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_mem_addr", mem_addr, 16'h0000);
        chk("rstmid_mem_wdata", mem_wdata, 16'h0000);
        extra_valid_cyc = -1;

        // Both requesters held: streak limit forces a fetch after four data grants.
        mem_m[16'h0100] = 16'hC0DE; lat_force = 1; renew_d = 1'b1; renew_i = 1'b1; clear_log();
        i_req = 1'b1; i_addr = 16'h0100; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0050;
        for (int k = 0; k < 120 && (d_cnt + i_cnt) < 10; k++) step();
        i_req = 1'b0; d_req = 1'b0; renew_d = 1'b0; renew_i = 1'b0;
        chk("fair_done_count", order_n, 10);
        chk("fair_grant_order", order_bits, 32'h0000_0210);
        chk("fair_i_rdata", last_i_rdata, 16'hC0DE);
        step(); step();

        // Three-cycle memory on a fetch.
        mem_m[16'h0002] = 16'h0F0F; lat_force = 3; clear_log();
        c0 = cyc; i_req = 1'b1; i_addr = 16'h0002;
        wait_done(1'b1, 20);
        step(); step();
        chk("lat3_done_cycle", last_i_cyc - c0, 5);
        chk("lat3_busy_cycles", busy_cnt, 5);
        chk("lat3_rdata", last_i_rdata, 16'h0F0F);
        chk("lat3_no_d_done", d_cnt, 0);

        // Random traffic with occasional resets.
        rand_mode = 1'b1; lat_force = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
            end else begin
                if (!i_req && $urandom_range(0, 3) == 0) new_i_random();
                if (!d_req && $urandom_range(0, 2) == 0) new_d_random();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
